// File: rtl/sys_mem_responder.sv
// System memory responder: 2**ADDR_W byte array behind a level-held
// read/write request handshake with fixed per-operation latency.
module sys_mem_responder #(
    parameter int ADDR_W    = 14,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [ADDR_W-1:0] addrout,
    input  logic [15:0]       datatomem,
    output logic              mem_resp,
    output logic [7:0]        datafrommem,
    output logic              busy,
    output logic              protocol_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] RD_M1 = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_M1 = 4'(WRITE_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              perr_q, perr_d;
    logic [7:0]        rdata_q;
    logic              commit;
    logic              act_req;
    logic              opp_req;
    logic [3:0]        lat_m1;
    logic [ADDR_W-1:0] addr_p1;

    logic [7:0] mem [2**ADDR_W];

    // op_q: 1 = write, 0 = read
    assign act_req = op_q ? write_req : read_req;
    assign opp_req = op_q ? read_req : write_req;
    assign lat_m1  = op_q ? WR_M1 : RD_M1;
    assign addr_p1 = addr_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        perr_d  = perr_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_req || write_req) begin
                    op_d    = write_req;
                    addr_d  = addrout;
                    data_d  = datatomem;
                    cnt_d   = 4'd0;
                    state_d = WAIT;
                    if (read_req && write_req) begin
                        perr_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (opp_req) begin
                    perr_d = 1'b1;
                end
                if (!act_req) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == lat_m1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            RESP: begin
                if (opp_req) begin
                    perr_d = 1'b1;
                end
                if (!act_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 16'd0;
            perr_q  <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            if (commit && !op_q) begin
                rdata_q <= mem[addr_q];
            end
        end
    end

    // Array has no reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (commit && op_q) begin
            mem[addr_q]  <= data_q[7:0];
            mem[addr_p1] <= data_q[15:8];
        end
    end

    assign mem_resp     = (state_q == RESP);
    assign busy         = (state_q == WAIT) || (state_q == RESP);
    assign datafrommem  = rdata_q;
    assign protocol_err = perr_q;

endmodule

// File: doc/sys_mem_responder.md
Name: sys_mem_responder

Overview:
Responder (memory) side of the processor–system-memory request/response interface. It accepts read and write requests from the memory interface unit and holds a 16 KByte byte-addressed array. After a fixed latency it completes each access and signals mem_resp. mem_resp is held until the requester withdraws its request. The block sits between the memory interface unit and top level, acting as the system memory model/controller.

Parameters:
ADDR_W, 14, address width; array depth = 2**ADDR_W bytes (16384)
READ_LAT, 4, cycles from request acceptance to mem_resp for reads; legal range 1..15
WRITE_LAT, 4, cycles from request acceptance to mem_resp for writes; legal range 1..15

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
read_req  input  1  read request from memory interface unit, level, held until mem_resp seen
write_req  input  1  write request from memory interface unit, level, held until mem_resp seen
addrout  input  ADDR_W  request byte address
datatomem  input  16  write data; [7:0] to addr, [15:8] to addr+1
mem_resp  output  1  access complete; held high until request deasserts
datafrommem  output  8  read data, valid while mem_resp high after a read
busy  output  1  high in WAIT or RESP
protocol_err  output  1  sticky; set on illegal request patterns, cleared only by reset

Behaviour:
- Reset (async, active-high): state=IDLE; mem_resp=0; datafrommem=0; busy=0; protocol_err=0; latency counter=0. Array contents are not cleared.
- State IDLE:
  - read_req or write_req sampled high -> capture op, addrout and datatomem into internal registers; counter=0; go to WAIT.
  - Both requests high -> treat as a write and set protocol_err.
- State WAIT:
  - counter increments each edge.
  - The active request sampled low (abort) -> return to IDLE; no array update, no mem_resp, datafrommem unchanged.
  - Otherwise, on the edge where counter reaches LAT-1 (READ_LAT or WRITE_LAT per captured op), go to RESP and set mem_resp=1.
  - Write: mem[a]<=d[7:0] and mem[(a+1) mod 2**ADDR_W]<=d[15:8] on that same edge. Address wraps 0x3FFF -> 0x0000.
  - Read: datafrommem<=mem[a] on that same edge.
- Latency: request first sampled at edge E0 -> mem_resp visible after edge E0+LAT.
- Inputs are captured at acceptance. Changes to addrout or datatomem during WAIT or RESP are ignored.
- State RESP:
  - mem_resp held high.
  - The captured request sampled low -> mem_resp=0 and go to IDLE. A new request is accepted from the following edge, so there is a minimum one idle cycle between accesses.
  - The opposite request rising while in RESP or WAIT sets protocol_err and is otherwise ignored.
- datafrommem holds its last read value until the next completed read. Writes and aborts do not change it.
- busy is combinational from state (high in WAIT or RESP).
- Reset asserted mid-WAIT: the access is discarded and no commit occurs. Reset asserted mid-RESP: an already-committed write remains in the array.
- Read of an address never written returns X in simulation. Benches pre-write before reading.

Test Plan:
- Write 0x1234 at addr 0x0010 (WRITE_LAT=4): mem_resp rises 4 cycles after acceptance. Then read 0x0010 -> 0x34 and read 0x0011 -> 0x12, each mem_resp 4 cycles after acceptance.
- Wrap: write 0xBEEF at 0x3FFF -> read 0x3FFF returns 0xEF and read 0x0000 returns 0xBE.
- Handshake hold: requester keeps read_req high 3 extra cycles after mem_resp -> mem_resp stays high those 3 cycles and drops the cycle after read_req drops. Back-to-back request next cycle is accepted only after one IDLE cycle.
- Abort: write 0xAAAA at 0x0020 then drop write_req at cycle 2 of WAIT -> no mem_resp, busy low next cycle. A subsequent read of 0x0020 returns the previously written value (0x55 after a prior write of 0x0055).
- Illegal: read_req and write_req high together at 0x0030 with data 0x00C3 -> protocol_err=1 (sticky), write performed, read of 0x0030 returns 0xC3.
- Async reset mid-WAIT of a write to 0x0040: outputs clear immediately without a clock edge. After reset, read of 0x0040 returns the pre-write value, with protocol_err=0 and datafrommem=0 before that read completes.
